// File: rtl/transmitter_physical_training_gen_pkg.sv
// Shared symbols and state encoding for the transmit-side training generator.
// The receiver aligner and tab calibration use the same comma and edge pattern.
package transmitter_physical_training_gen_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D21_5 = 8'hB5;

  typedef enum logic [1:0] {
    TX_TRAIN_IDLE  = 2'd0,
    TX_TRAIN_EDGE  = 2'd1,
    TX_TRAIN_ALIGN = 2'd2,
    TX_TRAIN_LINK  = 2'd3
  } tx_train_state_e;

endpackage

// File: rtl/transmitter_physical_training_gen_if.sv
// Upstream packet byte stream with valid/ready handshake.
interface transmitter_physical_training_gen_if;

  logic       packet_valid;
  logic       packet_k_en;
  logic [7:0] packet_byte;
  logic       packet_ready;

  modport master (output packet_valid, output packet_k_en, output packet_byte, input packet_ready);
  modport slave  (input packet_valid, input packet_k_en, input packet_byte, output packet_ready);

endinterface

// File: rtl/transmitter_physical_training_gen.sv
// Edge-training (D21.5), comma burst (K28.5) and link pass-through with periodic
// comma insertion, feeding the 8b10b encoder with registered symbols.
module transmitter_physical_training_gen
  import transmitter_physical_training_gen_pkg::*;
#(
  parameter int EDGE_CYCLES    = 256,
  parameter int ALIGN_CYCLES   = 64,
  parameter int COMMA_INTERVAL = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_train_start,
  transmitter_physical_training_gen_if.slave  pkt_if,
  output logic                                o_enc_k_en,
  output logic [7:0]                          o_enc_byte,
  output logic                                o_train_run,
  output logic                                o_link_up
);

  localparam longint CNT_RANGE = longint'(1) << CNT_WIDTH;

  generate
    if (EDGE_CYCLES < 1 || ALIGN_CYCLES < 1 || COMMA_INTERVAL < 2 ||
        longint'(EDGE_CYCLES) > CNT_RANGE || longint'(ALIGN_CYCLES) > CNT_RANGE ||
        longint'(COMMA_INTERVAL) > CNT_RANGE) begin : g_bad_param
      $error("transmitter_physical_training_gen: phase limits out of range for CNT_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] EDGE_LAST  = CNT_WIDTH'(EDGE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ALIGN_LAST = CNT_WIDTH'(ALIGN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] COMMA_LAST = CNT_WIDTH'(COMMA_INTERVAL - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  tx_train_state_e       state_q, state_d;
  logic [CNT_WIDTH-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_WIDTH-1:0]  comma_cnt_q, comma_cnt_d;
  logic                  enc_k_q, enc_k_d;
  logic [7:0]            enc_byte_q, enc_byte_d;
  logic                  comma_slot;
  logic                  packet_ready;

  assign comma_slot   = (state_q == TX_TRAIN_LINK) && (comma_cnt_q == COMMA_LAST);
  assign packet_ready = (state_q == TX_TRAIN_LINK) && !comma_slot && !i_train_start;

  assign pkt_if.packet_ready = packet_ready;
  assign o_enc_k_en          = enc_k_q;
  assign o_enc_byte          = enc_byte_q;
  assign o_train_run         = (state_q == TX_TRAIN_EDGE) || (state_q == TX_TRAIN_ALIGN);
  assign o_link_up           = (state_q == TX_TRAIN_LINK);

  // The symbol register is loaded with the byte belonging to the next state,
  // so the output lines up cycle-for-cycle with o_train_run / o_link_up.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    comma_cnt_d = comma_cnt_q;
    enc_k_d     = 1'b1;
    enc_byte_d  = K28_5;
    if (i_train_start) begin
      state_d     = TX_TRAIN_EDGE;
      phase_cnt_d = '0;
      comma_cnt_d = '0;
      enc_k_d     = 1'b0;
      enc_byte_d  = D21_5;
    end else begin
      case (state_q)
        TX_TRAIN_IDLE: begin
          state_d = TX_TRAIN_IDLE;
        end
        TX_TRAIN_EDGE: begin
          if (phase_cnt_q == EDGE_LAST) begin
            state_d     = TX_TRAIN_ALIGN;
            phase_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_ONE;
            enc_k_d     = 1'b0;
            enc_byte_d  = D21_5;
          end
        end
        TX_TRAIN_ALIGN: begin
          if (phase_cnt_q == ALIGN_LAST) begin
            state_d     = TX_TRAIN_LINK;
            phase_cnt_d = '0;
            comma_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_ONE;
          end
        end
        TX_TRAIN_LINK: begin
          comma_cnt_d = comma_slot ? '0 : comma_cnt_q + CNT_ONE;
          if (packet_ready && pkt_if.packet_valid) begin
            enc_k_d    = pkt_if.packet_k_en;
            enc_byte_d = pkt_if.packet_byte;
          end
        end
        default: begin
          state_d = TX_TRAIN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= TX_TRAIN_IDLE;
      phase_cnt_q <= '0;
      comma_cnt_q <= '0;
      enc_k_q     <= 1'b1;
      enc_byte_q  <= K28_5;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      enc_k_q     <= enc_k_d;
      enc_byte_q  <= enc_byte_d;
    end
  end

endmodule

// File: tb/tb_transmitter_physical_training_gen.sv
// Directed bench: table of per-cycle inputs and expected outputs, plus restart
// and reset corner sequences, with EDGE=4, ALIGN=3, COMMA_INTERVAL=5.
module tb_transmitter_physical_training_gen;

  localparam logic [8:0] KC = 9'h1BC;
  localparam logic [8:0] DE = 9'h0B5;

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic       k;
    logic [7:0] data;
    logic       exp_ready;
    logic [8:0] exp_enc;
    logic       exp_run;
    logic       exp_link;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       train_start;
  logic       enc_k;
  logic [7:0] enc_byte;
  logic       train_run;
  logic       link_up;

  int n_vec;
  int n_err;
  vec_t vecs[$];

  transmitter_physical_training_gen_if pkt_if ();

  transmitter_physical_training_gen #(
    .EDGE_CYCLES(4), .ALIGN_CYCLES(3), .COMMA_INTERVAL(5), .CNT_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_train_start(train_start), .pkt_if(pkt_if),
    .o_enc_k_en(enc_k), .o_enc_byte(enc_byte), .o_train_run(train_run), .o_link_up(link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input logic v, input logic k,
                              input logic [7:0] b, input logic er, input logic [8:0] ee,
                              input logic erun, input logic elink);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.k = k; t.data = b;
    t.exp_ready = er; t.exp_enc = ee; t.exp_run = erun; t.exp_link = elink;
    vecs.push_back(t);
  endfunction

  // Drive one cycle's inputs after the falling edge and check what is visible in that cycle.
  task automatic step(input string tag, input logic r, input logic s, input logic v,
                      input logic k, input logic [7:0] b, input logic er,
                      input logic [8:0] ee, input logic erun, input logic elink);
    logic [8:0] enc;
    @(negedge clk);
    rst = r; train_start = s;
    pkt_if.packet_valid = v; pkt_if.packet_k_en = k; pkt_if.packet_byte = b;
    #1;
    enc = {enc_k, enc_byte};
    n_vec++;
    $display("vec %0d %s: rst=%b start=%b valid=%b in=%h ready=%b enc=%h run=%b link=%b",
             n_vec, tag, r, s, v, {k, b}, pkt_if.packet_ready, enc, train_run, link_up);
    if (pkt_if.packet_ready !== er) begin
      $display("FAIL %s vec %0d ready: got %b expected %b", tag, n_vec, pkt_if.packet_ready, er);
      n_err++;
    end
    if (enc !== ee) begin
      $display("FAIL %s vec %0d enc: got %h expected %h", tag, n_vec, enc, ee);
      n_err++;
    end
    if (train_run !== erun) begin
      $display("FAIL %s vec %0d train_run: got %b expected %b", tag, n_vec, train_run, erun);
      n_err++;
    end
    if (link_up !== elink) begin
      $display("FAIL %s vec %0d link_up: got %b expected %b", tag, n_vec, link_up, elink);
      n_err++;
    end
  endtask

  // Full 4+3 training run after a start pulse, ending on the first LINK cycle.
  task automatic train_check(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 0, 0, 0, 0, 8'h00, 0, DE, 1, 0);
    for (int i = 0; i < 3; i++) step(tag, 0, 0, 0, 0, 8'h00, 0, KC, 1, 0);
    step(tag, 0, 0, 0, 0, 8'h00, 1, KC, 0, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; train_start = 1'b0;
    pkt_if.packet_valid = 1'b0; pkt_if.packet_k_en = 1'b0; pkt_if.packet_byte = 8'h00;

    // reset and idle
    add(1, 0, 0, 0, 8'h00, 0, KC, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 8'h00, 0, KC, 0, 0);
    add(0, 0, 1, 0, 8'h55, 0, KC, 0, 0);
    // training sequence
    add(0, 1, 0, 0, 8'h00, 0, KC, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 8'h00, 0, DE, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'h00, 0, KC, 1, 0);
    // LINK, valid held: comma every 5th cycle
    add(0, 0, 1, 0, 8'h01, 1, KC, 0, 1);
    add(0, 0, 1, 0, 8'h02, 1, 9'h001, 0, 1);
    add(0, 0, 1, 0, 8'h03, 1, 9'h002, 0, 1);
    add(0, 0, 1, 0, 8'h04, 1, 9'h003, 0, 1);
    add(0, 0, 1, 0, 8'h05, 0, 9'h004, 0, 1);
    add(0, 0, 1, 0, 8'h05, 1, KC, 0, 1);
    add(0, 0, 1, 0, 8'h06, 1, 9'h005, 0, 1);
    add(0, 0, 1, 0, 8'h07, 1, 9'h006, 0, 1);
    add(0, 0, 1, 0, 8'h08, 1, 9'h007, 0, 1);
    add(0, 0, 1, 0, 8'h09, 0, 9'h008, 0, 1);
    // LINK, sparse valid
    add(0, 0, 0, 0, 8'h00, 1, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, KC, 0, 1);
    add(0, 0, 1, 0, 8'h11, 1, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0, 9'h011, 0, 1);
    add(0, 0, 1, 0, 8'h12, 1, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, 9'h012, 0, 1);
    add(0, 0, 1, 1, 8'h1C, 1, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, 9'h11C, 0, 1);
    add(0, 0, 1, 0, 8'h14, 0, KC, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, KC, 0, 1);
    // restart from LINK with a byte on offer
    add(0, 1, 1, 0, 8'hAA, 0, KC, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 8'hAA, 0, DE, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 8'hAA, 0, KC, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1, KC, 0, 1);

    repeat (2) @(posedge clk);
    foreach (vecs[i])
      step("table", vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].k, vecs[i].data,
           vecs[i].exp_ready, vecs[i].exp_enc, vecs[i].exp_run, vecs[i].exp_link);

    // restart while in EDGE resets the edge count
    step("edge_restart", 0, 1, 0, 0, 8'h00, 0, KC, 0, 1);
    step("edge_restart", 0, 0, 0, 0, 8'h00, 0, DE, 1, 0);
    step("edge_restart", 0, 1, 0, 0, 8'h00, 0, DE, 1, 0);
    train_check("edge_restart");

    // reset together with start in mid-ALIGN wins and lands in IDLE
    step("rst_align", 0, 1, 0, 0, 8'h00, 0, KC, 0, 1);
    for (int i = 0; i < 4; i++) step("rst_align", 0, 0, 0, 0, 8'h00, 0, DE, 1, 0);
    step("rst_align", 1, 1, 0, 0, 8'h00, 0, KC, 1, 0);
    step("rst_align", 0, 0, 0, 0, 8'h00, 0, KC, 0, 0);
    step("rst_align", 0, 0, 1, 0, 8'h77, 0, KC, 0, 0);
    step("rst_align", 0, 1, 0, 0, 8'h00, 0, KC, 0, 0);
    train_check("rst_align");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
